pp_accumulator: RTL and testbench

Sequential partial-product consumer for the signed multiplier datapath. It accepts one sign-extended, pre-shifted partial product per cycle over a valid/ready stream, as produced by the partial-product shifters. It sums a fixed number of them, with optional subtraction of the sign-row product, and presents the final product on a valid/ready output. It sits between the partial-product generation stage and the multiplier result register.

---
 rtl/pp_accumulator.sv | 79 +++++++
 tb/tb_pp_accumulator.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pp_accumulator.sv
// Sums NUM_PP signed, pre-shifted partial products (add or subtract each) and
// presents the finished product on a valid/ready output stream.
module pp_accumulator #(
  parameter int DATA_WIDTH_2  = 8,
  parameter int DATA_WIDTH_PP = 16,
  parameter int NUM_PP        = DATA_WIDTH_2 + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       pp_valid,
  output logic                       pp_ready,
  input  logic [DATA_WIDTH_PP:0]     pp_data,
  input  logic                       pp_sub,
  output logic                       sum_valid,
  input  logic                       sum_ready,
  output logic [DATA_WIDTH_PP:0]     sum_data,
  output logic [$clog2(NUM_PP+1)-1:0] pp_count
);

  localparam int CNT_W = $clog2(NUM_PP + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PP - 1);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_WIDTH_PP:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic pp_accept;
  logic sum_accept;

  assign pp_accept  = (state_q == ACC)  && pp_valid;
  assign sum_accept = (state_q == DONE) && sum_ready;

  // clr outranks both handshakes, so a coincident accept is simply dropped.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (pp_accept) begin
      acc_d = pp_sub ? (acc_q - pp_data) : (acc_q + pp_data);
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_CNT) begin
        state_d = DONE;
      end
    end else if (sum_accept) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are decoded from flops only: no path from pp_valid/sum_ready.
  assign pp_ready  = (state_q == ACC);
  assign sum_valid = (state_q == DONE);
  assign sum_data  = acc_q;
  assign pp_count  = cnt_q;

endmodule

// File: tb/tb_pp_accumulator.sv
// Randomized and directed checks of pp_accumulator against a queue-based
// model that recomputes the product from the list of accepted partial products.
module tb_pp_accumulator;

  localparam int DW  = 16;
  localparam int NPP = 9;
  localparam int CW  = $clog2(NPP + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          pp_valid;
  logic          pp_ready;
  logic [DW:0]   pp_data;
  logic          pp_sub;
  logic          sum_valid;
  logic          sum_ready;
  logic [DW:0]   sum_data;
  logic [CW-1:0] pp_count;

  int checks   = 0;
  int failures = 0;

  // Model state: the accepted partial products of the current product.
  logic [DW:0] q_data[$];
  logic        q_sub[$];

  pp_accumulator #(
    .DATA_WIDTH_2 (8),
    .DATA_WIDTH_PP(DW),
    .NUM_PP       (NPP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .pp_valid (pp_valid),
    .pp_ready (pp_ready),
    .pp_data  (pp_data),
    .pp_sub   (pp_sub),
    .sum_valid(sum_valid),
    .sum_ready(sum_ready),
    .sum_data (sum_data),
    .pp_count (pp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW:0] model_sum();
    logic [DW:0] s;
    s = '0;
    foreach (q_data[i]) s = q_sub[i] ? s - q_data[i] : s + q_data[i];
    return s;
  endfunction

  task automatic model_clear();
    q_data.delete();
    q_sub.delete();
  endtask

  task automatic check_outputs(input string tag);
    logic done;
    done = (q_data.size() == NPP);
    chk({tag, ".sum_data"},  32'(sum_data),  32'(model_sum()));
    chk({tag, ".pp_count"},  32'(pp_count),  32'(q_data.size()));
    chk({tag, ".pp_ready"},  32'(pp_ready),  32'(!done));
    chk({tag, ".sum_valid"}, 32'(sum_valid), 32'(done));
  endtask

  // One clock cycle: drive inputs, take the edge, advance the model, compare.
  task automatic step(input string tag, input logic v, input logic [DW:0] d,
                      input logic s, input logic sr, input logic c);
    logic done;
    pp_valid  = v;
    pp_data   = d;
    pp_sub    = s;
    sum_ready = sr;
    clr       = c;
    done      = (q_data.size() == NPP);
    @(posedge clk);
    if (c) begin
      model_clear();
    end else if (!done && v) begin
      q_data.push_back(d);
      q_sub.push_back(s);
    end else if (done && sr) begin
      model_clear();
    end
    #1;
    check_outputs(tag);
    $display("cycle %s v=%0b d=0x%05h sub=%0b sr=%0b clr=%0b -> sum=0x%05h cnt=%0d sv=%0b",
             tag, v, d, s, sr, c, sum_data, pp_count, sum_valid);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; pp_valid = 1'b0; pp_data = '0; pp_sub = 1'b0; sum_ready = 1'b0;
    #1;
    check_outputs("reset");
    #13 rst_n = 1'b1;
    @(posedge clk); #1;

    // Positive product 3*5: 3 at shift 0, 12 at shift 2.
    for (int i = 0; i < NPP; i++)
      step("pos", 1'b1, (i == 0) ? 17'd3 : (i == 2) ? 17'd12 : 17'd0, 1'b0, 1'b0, 1'b0);
    chk("pos.value", 32'(sum_data), 32'h0000F);
    // Backpressure: sum held, extra pp pulses ignored.
    for (int i = 0; i < 5; i++) step("bp", 1'b1, 17'h00123, 1'b0, 1'b0, 1'b0);
    chk("bp.value", 32'(sum_data), 32'h0000F);
    step("bp.drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Negative operand.
    for (int i = 0; i < NPP; i++)
      step("neg", 1'b1, (i == 0) ? 17'h1FFFD : (i == 2) ? 17'h1FFF4 : 17'd0, 1'b0, 1'b1, 1'b0);
    chk("neg.value", 32'(sum_data), 32'h1FFF1);
    step("neg.drain", 1'b1, 17'h00055, 1'b0, 1'b1, 1'b0);

    // Sign-row subtract.
    for (int i = 0; i < NPP; i++)
      step("subrow", 1'b1, (i == NPP - 1) ? 17'h00100 : 17'd0, (i == NPP - 1), 1'b0, 1'b0);
    chk("subrow.value", 32'(sum_data), 32'h1FF00);
    step("subrow.drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Wrap-around.
    for (int i = 0; i < NPP; i++)
      step("wrap", 1'b1, (i == 0) ? 17'h1FFFF : (i == 1) ? 17'h00002 : 17'd0, 1'b0, 1'b0, 1'b0);
    chk("wrap.value", 32'(sum_data), 32'h00001);
    step("wrap.drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // clr mid-product with a coincident accept.
    for (int i = 0; i < 4; i++) step("clr.pre", 1'b1, 17'h00011, 1'b0, 1'b0, 1'b0);
    step("clr", 1'b1, 17'h00400, 1'b0, 1'b0, 1'b1);
    chk("clr.count", 32'(pp_count), 32'd0);
    for (int i = 0; i < NPP; i++)
      step("clr.post", 1'b1, (i == 0) ? 17'd7 : 17'd0, 1'b0, 1'b0, 1'b0);
    chk("clr.value", 32'(sum_data), 32'h00007);
    step("clr.drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between edges after 6 accepts.
    for (int i = 0; i < 6; i++) step("rst.pre", 1'b1, 17'h00021, 1'b0, 1'b0, 1'b0);
    pp_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs("rst.async");
    #2 rst_n = 1'b1;
    for (int i = 0; i < NPP; i++)
      step("rst.post", 1'b1, 17'(i + 1), 1'b0, 1'b0, 1'b0);
    chk("rst.value", 32'(sum_data), 32'd45);
    step("rst.drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 3) != 0), 17'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
